// File: rtl/amns_mm_sequencer.sv
// ---------------------------------------------------------------------------
// amns_mm_sequencer
//
// Top-level operation sequencer for the AMNS modular multiplier. A host start
// request launches one full operation: operand load (POLY_memory_control),
// multiplication (multiplier core), then result store (POLY_memory_control).
// The single BRAM port belongs to the host while the sequencer is idle and to
// POLY_memory_control while an operation is running.
//
// State table:
//   state   | meaning
//   IDLE    | host owns BRAM, waiting for start_i
//   LOAD    | operand load running, waiting for load_done_i
//   COMPUTE | multiplier running, waiting for mult_done_i
//   STORE   | result store running, waiting for store_done_i
//   DONE    | one-cycle completion, done_o high, start_i ignored
//
// Ports:
//   clock_i, reset_i             clock, synchronous active-high reset
//   start_i                      host request to run one multiplication
//   busy_o, done_o               operation in progress / completion pulse
//   host_we_i, host_addr_i       host BRAM access
//   ctrl_BRAM_we_i/addr_i        BRAM access from POLY_memory_control
//   BRAM_we_o, BRAM_addr_o       muxed BRAM port (combinational)
//   load/mult/store_start_o      one-cycle start pulses to the sub-blocks
//   load/mult/store_done_i       completion strobes from the sub-blocks
//   host_conflict_o              sticky: host wrote while busy
//   cycle_count_o                saturating latency of LOAD+COMPUTE+STORE
// ---------------------------------------------------------------------------
module amns_mm_sequencer #(
    parameter int WORD_WIDTH      = 17,
    parameter int N               = 5,
    parameter int S               = 4,
    parameter int CYCLE_CNT_WIDTH = 16,
    localparam int ADDR_LEN       = $clog2(4*N*S+N)+1
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    input  logic                       host_we_i,
    input  logic [ADDR_LEN-1:0]        host_addr_i,
    input  logic                       ctrl_BRAM_we_i,
    input  logic [ADDR_LEN-1:0]        ctrl_BRAM_addr_i,
    output logic                       BRAM_we_o,
    output logic [ADDR_LEN-1:0]        BRAM_addr_o,
    output logic                       load_start_o,
    input  logic                       load_done_i,
    output logic                       mult_start_o,
    input  logic                       mult_done_i,
    output logic                       store_start_o,
    input  logic                       store_done_i,
    output logic                       host_conflict_o,
    output logic [CYCLE_CNT_WIDTH-1:0] cycle_count_o
);

    // WORD_WIDTH is only carried through the hierarchy; reject nonsense values.
    if (WORD_WIDTH < 1 || CYCLE_CNT_WIDTH < 1) begin : g_param_check
        $error("amns_mm_sequencer: WORD_WIDTH and CYCLE_CNT_WIDTH must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        STORE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                     state_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       load_start_q;
    logic                       mult_start_q;
    logic                       store_start_q;
    logic                       conflict_q;
    logic [CYCLE_CNT_WIDTH-1:0] cycle_cnt_q;
    logic [CYCLE_CNT_WIDTH-1:0] cycle_cnt_d;
    logic                       in_op;

    assign in_op = (state_q == LOAD) || (state_q == COMPUTE) || (state_q == STORE);

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (in_op && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            load_start_q  <= 1'b0;
            mult_start_q  <= 1'b0;
            store_start_q <= 1'b0;
            conflict_q    <= 1'b0;
            cycle_cnt_q   <= '0;
        end else begin
            load_start_q  <= 1'b0;
            mult_start_q  <= 1'b0;
            store_start_q <= 1'b0;
            done_q        <= 1'b0;
            cycle_cnt_q   <= cycle_cnt_d;

            // busy_q is low in IDLE, so this never races the clear on start.
            if (busy_q && host_we_i) begin
                conflict_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q      <= LOAD;
                        load_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        cycle_cnt_q  <= '0;
                        conflict_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_done_i) begin
                        state_q      <= COMPUTE;
                        mult_start_q <= 1'b1;
                    end
                end
                COMPUTE: begin
                    if (mult_done_i) begin
                        state_q       <= STORE;
                        store_start_q <= 1'b1;
                    end
                end
                STORE: begin
                    if (store_done_i) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Host traffic outside IDLE/DONE never reaches the BRAM.
    always_comb begin
        BRAM_we_o   = ctrl_BRAM_we_i;
        BRAM_addr_o = ctrl_BRAM_addr_i;
        if ((state_q == IDLE) || (state_q == DONE)) begin
            BRAM_we_o   = host_we_i;
            BRAM_addr_o = host_addr_i;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign load_start_o    = load_start_q;
    assign mult_start_o    = mult_start_q;
    assign store_start_o   = store_start_q;
    assign host_conflict_o = conflict_q;
    assign cycle_count_o   = cycle_cnt_q;

endmodule

// File: tb/tb_amns_mm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_amns_mm_sequencer
//
// Drives the sequencer cycle by cycle from the falling clock edge. An operation
// is modelled as three phases with chosen latencies; from those the bench
// derives which start pulse must be visible in each cycle, the latency count,
// the BRAM owner and the sticky conflict flag. The counter width is reduced so
// saturation can be reached in a short run.
// ---------------------------------------------------------------------------
module tb_amns_mm_sequencer;

    localparam int AW    = 8;
    localparam int CNT_W = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock_i = 1'b0;
    logic             reset_i;
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic             host_we_i;
    logic [AW-1:0]    host_addr_i;
    logic             ctrl_BRAM_we_i;
    logic [AW-1:0]    ctrl_BRAM_addr_i;
    logic             BRAM_we_o;
    logic [AW-1:0]    BRAM_addr_o;
    logic             load_start_o;
    logic             load_done_i;
    logic             mult_start_o;
    logic             mult_done_i;
    logic             store_start_o;
    logic             store_done_i;
    logic             host_conflict_o;
    logic [CNT_W-1:0] cycle_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state carried between runs.
    bit sticky_conf = 1'b0;
    int last_cc     = 0;

    amns_mm_sequencer #(
        .WORD_WIDTH      (17),
        .N               (5),
        .S               (4),
        .CYCLE_CNT_WIDTH (CNT_W)
    ) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .host_we_i        (host_we_i),
        .host_addr_i      (host_addr_i),
        .ctrl_BRAM_we_i   (ctrl_BRAM_we_i),
        .ctrl_BRAM_addr_i (ctrl_BRAM_addr_i),
        .BRAM_we_o        (BRAM_we_o),
        .BRAM_addr_o      (BRAM_addr_o),
        .load_start_o     (load_start_o),
        .load_done_i      (load_done_i),
        .mult_start_o     (mult_start_o),
        .mult_done_i      (mult_done_i),
        .store_start_o    (store_start_o),
        .store_done_i     (store_done_i),
        .host_conflict_o  (host_conflict_o),
        .cycle_count_o    (cycle_count_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // One operation. Entered so that the next falling edge sees IDLE; returns
    // while the DUT is in its DONE cycle.
    //   host_mode: 0 quiet, 1 random host traffic, 2 one host write in COMPUTE
    //   spur_mode: 0 none, 1 random, 2 every cycle (done strobes of other phases)
    task automatic run_op(input int ll, input int lc, input int ls,
                          input int host_mode, input int spur_mode, input bit hold_start);
        int         lat[3];
        int         j;
        bit         conf;
        bit         spur;
        logic [5:0] exp_v;
        logic [5:0] act_v;
        logic [2:0] dn;

        lat[0] = ll; lat[1] = lc; lat[2] = ls;

        // IDLE cycle: host owns BRAM, previous results held.
        @(negedge clock_i);
        host_we_i        = (host_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        host_addr_i      = AW'($urandom);
        ctrl_BRAM_we_i   = 1'($urandom_range(0, 1));
        ctrl_BRAM_addr_i = AW'($urandom);
        {load_done_i, mult_done_i, store_done_i} = 3'b000;
        start_i = 1'b1;
        #1;
        exp_v = {3'b000, 1'b0, 1'b0, sticky_conf};
        act_v = {load_start_o, mult_start_o, store_start_o, busy_o, done_o, host_conflict_o};
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL idle_ctl: got %b expected %b", act_v, exp_v);
        end
        n_tests++;
        if (cycle_count_o !== CNT_W'(last_cc)) begin
            n_fail++;
            $display("FAIL idle_count: got %0d expected %0d", cycle_count_o, last_cc);
        end
        n_tests++;
        if ({BRAM_we_o, BRAM_addr_o} !== {host_we_i, host_addr_i}) begin
            n_fail++;
            $display("FAIL idle_bram: got we=%b addr=%0d expected we=%b addr=%0d",
                     BRAM_we_o, BRAM_addr_o, host_we_i, host_addr_i);
        end

        j    = 0;
        conf = 1'b0;
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 1; k <= lat[ph]; k++) begin
                @(negedge clock_i);
                if (!hold_start) start_i = 1'b0;
                ctrl_BRAM_we_i   = 1'($urandom_range(0, 1));
                ctrl_BRAM_addr_i = AW'($urandom);
                host_addr_i      = AW'($urandom);
                case (host_mode)
                    1: host_we_i = 1'($urandom_range(0, 1));
                    2: begin
                        host_we_i = (ph == 1 && k == 1);
                        if (ph == 1 && k == 1) begin
                            host_addr_i      = AW'(3);
                            ctrl_BRAM_we_i   = 1'b0;
                            ctrl_BRAM_addr_i = AW'(9);
                        end
                    end
                    default: host_we_i = 1'b0;
                endcase
                dn = 3'b000;
                for (int p = 0; p < 3; p++) begin
                    if (p == ph) begin
                        dn[p] = (k == lat[ph]);
                    end else begin
                        spur  = (spur_mode == 2) || (spur_mode == 1 && $urandom_range(0, 2) == 0);
                        dn[p] = spur;
                    end
                end
                load_done_i  = dn[0];
                mult_done_i  = dn[1];
                store_done_i = dn[2];
                #1;
                exp_v = {(ph == 0 && k == 1), (ph == 1 && k == 1), (ph == 2 && k == 1),
                         1'b1, 1'b0, conf};
                act_v = {load_start_o, mult_start_o, store_start_o, busy_o, done_o, host_conflict_o};
                n_tests++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL busy_ctl ph%0d cyc%0d: got %b expected %b", ph, k, act_v, exp_v);
                end
                n_tests++;
                if (cycle_count_o !== CNT_W'(sat(j))) begin
                    n_fail++;
                    $display("FAIL busy_count ph%0d cyc%0d: got %0d expected %0d",
                             ph, k, cycle_count_o, sat(j));
                end
                n_tests++;
                if ({BRAM_we_o, BRAM_addr_o} !== {ctrl_BRAM_we_i, ctrl_BRAM_addr_i}) begin
                    n_fail++;
                    $display("FAIL busy_bram ph%0d cyc%0d: got we=%b addr=%0d expected we=%b addr=%0d",
                             ph, k, BRAM_we_o, BRAM_addr_o, ctrl_BRAM_we_i, ctrl_BRAM_addr_i);
                end
                conf = conf | host_we_i;
                j++;
            end
        end

        // DONE cycle.
        @(negedge clock_i);
        {load_done_i, mult_done_i, store_done_i} = 3'b000;
        host_we_i   = (host_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        host_addr_i = AW'($urandom);
        #1;
        exp_v = {3'b000, 1'b0, 1'b1, conf};
        act_v = {load_start_o, mult_start_o, store_start_o, busy_o, done_o, host_conflict_o};
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL done_ctl: got %b expected %b", act_v, exp_v);
        end
        n_tests++;
        if (cycle_count_o !== CNT_W'(sat(j))) begin
            n_fail++;
            $display("FAIL done_count: got %0d expected %0d", cycle_count_o, sat(j));
        end
        n_tests++;
        if ({BRAM_we_o, BRAM_addr_o} !== {host_we_i, host_addr_i}) begin
            n_fail++;
            $display("FAIL done_bram: got we=%b addr=%0d expected we=%b addr=%0d",
                     BRAM_we_o, BRAM_addr_o, host_we_i, host_addr_i);
        end
        sticky_conf = conf;
        last_cc     = sat(j);
    endtask

    task automatic test_reset();
        reset_i          = 1'b1;
        start_i          = 1'b0;
        host_we_i        = 1'b1;
        host_addr_i      = AW'(7);
        ctrl_BRAM_we_i   = 1'b0;
        ctrl_BRAM_addr_i = AW'(0);
        load_done_i      = 1'b0;
        mult_done_i      = 1'b0;
        store_done_i     = 1'b0;
        @(negedge clock_i);
        #1;
        n_tests++;
        if ({load_start_o, mult_start_o, store_start_o, busy_o, done_o, host_conflict_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected 000000",
                     {load_start_o, mult_start_o, store_start_o, busy_o, done_o, host_conflict_o});
        end
        n_tests++;
        if (cycle_count_o !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", cycle_count_o);
        end
        n_tests++;
        if (BRAM_we_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_bram_we: got %b expected 1", BRAM_we_o);
        end
        n_tests++;
        if (BRAM_addr_o !== AW'(7)) begin
            n_fail++;
            $display("FAIL reset_bram_addr: got %0d expected 7", BRAM_addr_o);
        end
        reset_i     = 1'b0;
        host_we_i   = 1'b0;
        sticky_conf = 1'b0;
        last_cc     = 0;
    endtask

    task automatic test_nominal();
        run_op(10, 20, 5, 0, 0, 1'b0);
        n_tests++;
        if (cycle_count_o !== CNT_W'(35)) begin
            n_fail++;
            $display("FAIL nominal_count: got %0d expected 35", cycle_count_o);
        end
    endtask

    task automatic test_conflict();
        run_op(3, 4, 2, 2, 0, 1'b0);
        n_tests++;
        if (host_conflict_o !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_in_done: got %b expected 1", host_conflict_o);
        end
        // The next run checks the flag held in IDLE and cleared after start.
        run_op(2, 2, 2, 0, 0, 1'b0);
    endtask

    task automatic test_spurious_done();
        run_op(5, 3, 2, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            run_op($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12),
                   1, 1, 1'b0);
        end
    endtask

    task automatic test_saturation();
        run_op(30, 30, 10, 1, 0, 1'b0);
        n_tests++;
        if (cycle_count_o !== CNT_W'(CNT_MAX)) begin
            n_fail++;
            $display("FAIL sat_count: got %0d expected %0d", cycle_count_o, CNT_MAX);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            run_op(1, 1, 1, 0, 0, 1'b1);
            n_tests++;
            if (cycle_count_o !== CNT_W'(3)) begin
                n_fail++;
                $display("FAIL b2b_count run%0d: got %0d expected 3", r, cycle_count_o);
            end
        end
        // Still held: the following IDLE check confirms DONE ignored start_i.
        run_op(1, 1, 1, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_store();
        @(negedge clock_i);
        start_i = 1'b1;
        @(negedge clock_i);
        start_i     = 1'b0;
        load_done_i = 1'b1;
        @(negedge clock_i);
        load_done_i = 1'b0;
        mult_done_i = 1'b1;
        @(negedge clock_i);
        mult_done_i = 1'b0;
        #1;
        n_tests++;
        if ({store_start_o, busy_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_store_entry: got %b expected 11", {store_start_o, busy_o});
        end
        reset_i = 1'b1;
        @(negedge clock_i);
        reset_i = 1'b0;
        #1;
        n_tests++;
        if ({load_start_o, mult_start_o, store_start_o, busy_o, done_o, host_conflict_o,
             cycle_count_o} !== '0) begin
            n_fail++;
            $display("FAIL mid_store_reset: got ctl=%b count=%0d expected all zero",
                     {load_start_o, mult_start_o, store_start_o, busy_o, done_o, host_conflict_o},
                     cycle_count_o);
        end
        @(negedge clock_i);
        @(negedge clock_i);
        store_done_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock_i);
            store_done_i = 1'b0;
            #1;
            n_tests++;
            if ({done_o, busy_o, store_start_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL late_store_done cyc%0d: got %b expected 000",
                         c, {done_o, busy_o, store_start_o});
            end
        end
        sticky_conf = 1'b0;
        last_cc     = 0;
        // Recovery: a normal run must work after the aborted one.
        run_op(2, 3, 4, 1, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_conflict();
        test_spurious_done();
        test_random();
        test_saturation();
        test_back_to_back();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/amns_mm_sequencer.md
Name: amns_mm_sequencer

Overview:
Top-level operation sequencer for the AMNS modular multiplier. It accepts a host start request and runs the full operation in order: operand load via POLY_memory_control, then the multiplier core, then result store. It arbitrates the single BRAM port: the host owns it while idle, and POLY_memory_control owns it while busy. It also reports operation latency and any illegal host access made while busy.

Parameters:
WORD_WIDTH, 17, DSP word width (passed through, not used internally)
N, 5, number of AMNS polynomial coefficients
S, 4, WORD_WIDTH blocks per coefficient
CYCLE_CNT_WIDTH, 16, width of the latency counter
(localparam ADDR_LEN = $clog2(4*N*S+N)+1)

Ports:
clock_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
start_i  in  1  host request to run one multiplication
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse
host_we_i  in  1  host BRAM write enable
host_addr_i  in  ADDR_LEN  host BRAM address
ctrl_BRAM_we_i  in  1  BRAM write enable from POLY_memory_control
ctrl_BRAM_addr_i  in  ADDR_LEN  BRAM address from POLY_memory_control
BRAM_we_o  out  1  muxed BRAM write enable
BRAM_addr_o  out  ADDR_LEN  muxed BRAM address
load_start_o  out  1  pulse to POLY_memory_control load_start_i
load_done_i  in  1  from POLY_memory_control load_done_o
mult_start_o  out  1  pulse to the multiplier core
mult_done_i  in  1  multiplier completion
store_start_o  out  1  pulse to POLY_memory_control store_start_i
store_done_i  in  1  from POLY_memory_control store_done_o
host_conflict_o  out  1  sticky flag: host wrote while busy
cycle_count_o  out  CYCLE_CNT_WIDTH  cycles spent in LOAD, COMPUTE and STORE for the last or current operation

Behaviour:
- Clock is clock_i. reset_i is synchronous and active-high.
- States are IDLE, LOAD, COMPUTE, STORE, DONE. The state register and every output except BRAM_we_o/BRAM_addr_o are registered.
- Reset, including mid-operation: next state is IDLE. All registered outputs go to 0 and cycle_count_o goes to 0.
- IDLE: busy_o=0. When start_i=1, the next state is LOAD. On that same edge: load_start_o<=1, busy_o<=1, cycle_count_o<=0, host_conflict_o<=0.
- LOAD: load_start_o is high only in the first LOAD cycle. load_done_i is sampled in every LOAD cycle, including the first. When load_done_i=1, the next state is COMPUTE and mult_start_o<=1 for one cycle.
- COMPUTE: when mult_done_i=1, the next state is STORE and store_start_o<=1 for one cycle.
- STORE: when store_done_i=1, the next state is DONE.
- DONE: lasts exactly one cycle with done_o=1 and busy_o=0, then the state returns to IDLE. start_i is ignored while in DONE.
- Done inputs that are not expected in the current state are ignored. Examples: mult_done_i during LOAD, or load_done_i during STORE.
- Start pulses: every *_start_o is exactly one cycle wide, and only one of them is high at a time.
- cycle_count_o: increments once per clock in LOAD, COMPUTE and STORE. It saturates at all-ones with no wrap-around. It holds its value in DONE and IDLE until the next accepted start.
- BRAM mux (combinational):
  - In IDLE or DONE: BRAM_we_o=host_we_i, BRAM_addr_o=host_addr_i.
  - Otherwise: BRAM_we_o=ctrl_BRAM_we_i, BRAM_addr_o=ctrl_BRAM_addr_i.
  - Host writes made while busy are dropped.
- host_conflict_o: set on the edge after any cycle with host_we_i=1 and busy_o=1. It stays set until an accepted start or a reset.
- If start_i is held high continuously, runs go back-to-back: each run ends with one DONE cycle, and the next start is accepted in the following IDLE cycle.

Test Plan:
1. Reset: assert reset_i for 1 cycle -> all outputs 0, state IDLE. With host_we_i=1 and host_addr_i=7: BRAM_we_o=1, BRAM_addr_o=7.
2. Nominal run: pulse start_i; stubs assert load_done_i in the 10th LOAD cycle, mult_done_i in the 20th COMPUTE cycle, and store_done_i in the 5th STORE cycle -> load_start_o, mult_start_o and store_start_o each pulse once, in order. done_o is high for 1 cycle, cycle_count_o=35, then the state returns to IDLE.
3. Conflict: host_we_i=1 with host_addr_i=3 during COMPUTE, while the ctrl inputs are we=0 and addr=9 -> BRAM_we_o=0, BRAM_addr_o=9, host_conflict_o=1 on the next edge. It stays 1 through DONE and clears on the next accepted start.
4. Spurious done: mult_done_i and store_done_i pulsed during LOAD -> state stays LOAD and no start pulses are issued. A later load_done_i advances the state to COMPUTE normally.
5. Reset mid-STORE: reset_i=1 for 1 cycle -> IDLE with all outputs 0. A store_done_i arriving 2 cycles later is ignored and done_o stays 0.
6. start_i held high across 2 runs (1-cycle stub responses) -> each run's cycle_count_o=3. The DONE cycle is followed by exactly 1 IDLE cycle before the next LOAD, and start_i is ignored while in DONE.
